moosic_note_player: RTL



---
 rtl/moosic_note_player.sv | 131 +++++++++++++
 1 files changed

// File: rtl/moosic_note_player.sv
// Tone stage: buffers (half-period, duration) note commands in a small FIFO
// and plays them back-to-back as a 1-bit square wave.
module moosic_note_player #(
  parameter int DEPTH       = 4,
  parameter int TICK_CYCLES = 250000,
  parameter int PW          = 16,
  parameter int DW          = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stop,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [PW-1:0]            cmd_period,
  input  logic [DW-1:0]            cmd_duration,
  output logic                     audio_out,
  output logic                     playing,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = $clog2(TICK_CYCLES);
  localparam logic [SW-1:0] PRE_LAST = SW'(TICK_CYCLES - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PLAY = 1'b1;

  typedef struct packed {
    logic [PW-1:0] period;
    logic [DW-1:0] duration;
  } cmd_t;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;

  logic [0:0]    state;
  logic [PW-1:0] period_r;
  logic [DW-1:0] remaining_r;
  logic [SW-1:0] prescale;
  logic [PW-1:0] phase;
  logic          audio_r;

  cmd_t head;
  logic push, pop, load, note_end, fifo_empty;

  // Handshake, pop/load decisions and end-of-note detection
  always_comb begin
    head       = mem[rd_ptr];
    fifo_empty = (level == '0);
    cmd_ready  = rst_n & ~stop & (level != LVL_FULL);
    push       = cmd_valid & cmd_ready;
    note_end   = (state == S_PLAY) && (prescale == PRE_LAST) &&
                 (remaining_r == DW'(1));
    // The head is consumed either from IDLE or exactly at a note's last edge,
    // which is what makes chaining gapless.
    pop        = ~stop & ~fifo_empty & ((state == S_IDLE) | note_end);
    load       = pop & (head.duration != '0);
  end

  // Command storage; writes are already gated by reset/stop via cmd_ready
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{period: cmd_period, duration: cmd_duration};
  end

  // FIFO pointers and occupancy; a full FIFO never accepts, even when popping
  always_ff @(posedge clk) begin
    if (!rst_n || stop) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Player FSM: load/chain notes, run the tick prescaler and tone phase
  always_ff @(posedge clk) begin
    if (!rst_n || stop) begin
      state       <= S_IDLE;
      period_r    <= '0;
      remaining_r <= '0;
      prescale    <= '0;
      phase       <= '0;
      audio_r     <= 1'b0;
    end else if (load) begin
      state       <= S_PLAY;
      period_r    <= head.period;
      remaining_r <= head.duration;
      prescale    <= '0;
      phase       <= '0;
      audio_r     <= 1'b0;
    end else if (note_end) begin
      state       <= S_IDLE;
      period_r    <= '0;
      remaining_r <= '0;
      prescale    <= '0;
      phase       <= '0;
      audio_r     <= 1'b0;
    end else if (state == S_PLAY) begin
      if (prescale == PRE_LAST) begin
        prescale    <= '0;
        remaining_r <= remaining_r - DW'(1);
      end else begin
        prescale <= prescale + SW'(1);
      end
      // Period 0 is a rest: phase and output stay parked at 0
      if (period_r != '0) begin
        if (phase == period_r - PW'(1)) begin
          phase   <= '0;
          audio_r <= ~audio_r;
        end else begin
          phase <= phase + PW'(1);
        end
      end
    end
  end

  assign audio_out  = audio_r;
  assign playing    = (state == S_PLAY);
  assign fifo_level = level;

endmodule
